seg7_write_arbiter: RTL
=======================

Name: seg7_write_arbiter

Overview:
- Shares the 4-digit 7-segment display register file between two requesters (A, B).
- Each requester submits a 16-bit hex value plus a 4-bit dot mask.
- The block arbitrates round-robin, encodes each nibble to active-low segment data, and issues four consecutive writes (en_w/waddr/data) into the display controller's write port.
- It is the only driver of that write port.

Parameters:
- LZ_BLANK, 1: 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits.
- ACTIVE_LOW, 1: 1 = data bits are inverted (0 = segment on); 0 = active-high encoding.

Ports:
- clk  in  1  system clock, same clock as the display controller write port
- rst  in  1  asynchronous, active-low reset
- req_a  in  1  requester A wants an update; held high until gnt_a
- val_a  in  16  A value; digit i = val_a[4i+3:4i]
- dots_a  in  4  A dot mask; bit i = dot on digit i
- gnt_a  out  1  one-cycle pulse; val_a/dots_a captured this cycle
- req_b, val_b, dots_b, gnt_b: same as A, for requester B
- busy  out  1  high while a write burst is in progress
- en_w  out  1  write enable to the display controller
- waddr  out  2  digit address being written
- data  out  8  {dot, g,f,e,d,c,b,a}, encoded per ACTIVE_LOW
- last_src  out  1  source of the most recent grant (0 = A, 1 = B)

Behaviour:
- All outputs are registered.
- Reset values: gnt_a=0, gnt_b=0, busy=0, en_w=0, waddr=0, data=8'hFF (ACTIVE_LOW=1) or 8'h00 (ACTIVE_LOW=0), last_src=1 (so A wins the first tie). The FSM resets to IDLE and the digit counter to 0.
- FSM states: IDLE, WRITE.
- IDLE, no request: all outputs hold their reset values except last_src.
- IDLE, request sampled at edge N: at edge N+1 the FSM enters WRITE and captures the winner's val/dots. For the cycle following edge N+1: gnt_x=1, last_src=x, busy=1, en_w=1, waddr=0, data=digit 0.
- Arbitration: with one request, that requester wins. With both, the winner is the source != last_src.
- WRITE: waddr increments 0,1,2,3 on successive cycles, with en_w=1 each cycle. gnt is high only in the first WRITE cycle.
- After the waddr=3 cycle: return to IDLE. busy=0 and en_w=0 for at least one cycle.
- Burst timing: the total is exactly 4 write cycles. The next grant's first write is no sooner than 2 cycles after the previous waddr=3 write.
- A request that drops before its grant is ignored; no partial burst occurs.
- Requests arriving during WRITE wait. A value change on val_x while req_x is high but not yet granted takes effect, since capture happens at grant.
- Segment encoding (active-high, bit0 = a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Data word: raw = {dot_i, seg}. data = ~raw if ACTIVE_LOW, else raw.
- Blanking (LZ_BLANK=1): digit i (i = 1..3) is blank when nibbles i..3 are all zero. A blank digit has seg = 7'h00 (raw), but its dot still follows dots_i.
- Reset mid-burst: the burst is aborted immediately. en_w drops asynchronously and no further writes occur. After reset release the block is in IDLE, and pending requests are re-arbitrated with A favoured.

Test Plan:
- Reset, then req_a=1, val_a=16'h12AF, dots_a=0 → gnt_a pulse; writes (waddr,data) = (0,8E) (1,88) (2,A4) (3,F9); busy high for 4 cycles; last_src=0.
- req_a and req_b both high from the first cycle after reset, val_b=16'h0000, dots_b=4'b0100 → A is served first, then B. B's burst writes (0,C0) (1,FF) (2,7F) (3,FF).
- LZ_BLANK=0, val_a=16'h0007 → writes (0,F8) (1,C0) (2,C0) (3,C0).
- req_b held high continuously, req_a pulsed high for 2 cycles during B's burst → A is not granted and no A writes appear; B bursts repeat with the required ≥1-cycle idle gap between them.
- rst asserted at the waddr=1 cycle → en_w=0 immediately; no waddr=2 write occurs; after release with req_a=1, a fresh 4-write burst starts at waddr=0.
- ACTIVE_LOW=0, val_a=16'h8888, dots_a=4'b1111 → all four writes carry data=FF.

Source files
------------

// File: rtl/seg7_write_arbiter.sv
// seg7_write_arbiter: round-robin arbiter that encodes a requester's hex value and writes it as a 4-digit burst
module seg7_write_arbiter #(
  parameter bit LZ_BLANK = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] val_a,
  input  logic [3:0]  dots_a,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic [15:0] val_b,
  input  logic [3:0]  dots_b,
  output logic        gnt_b,
  output logic        busy,
  output logic        en_w,
  output logic [1:0]  waddr,
  output logic [7:0]  data,
  output logic        last_src
);
  localparam logic [7:0] OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef enum logic {IDLE, WRITE} state_t;
  state_t st, st_n;
  logic ra_q, rb_q, pick_b, start;
  logic [15:0] v, v_n;
  logic [3:0] d, d_n;
  logic ls_n, ga_n, gb_n, busy_n, en_n;
  logic [1:0] wa_n;
  logic [7:0] dat_n;
  // a digit is blank when it and every more significant nibble are zero
  function automatic logic [7:0] enc(input logic [15:0] x, input logic [3:0] m, input logic [1:0] i);
    logic blank;
    logic [7:0] raw;
    blank = LZ_BLANK && i != 2'd0 && (x >> {i, 2'b00}) == 16'h0;
    raw = {m[i], blank ? 7'h00 : SEG[x[{i, 2'b00} +: 4]]};
    return ACTIVE_LOW ? ~raw : raw;
  endfunction
  // a request must be seen on two consecutive edges, so one that drops early never wins
  assign pick_b = req_b && rb_q && !(req_a && ra_q && last_src);
  assign start = st == IDLE && ((req_a && ra_q) || (req_b && rb_q));
  always_comb begin
    st_n = st;
    v_n = v;
    d_n = d;
    ls_n = last_src;
    ga_n = 1'b0;
    gb_n = 1'b0;
    busy_n = 1'b0;
    en_n = 1'b0;
    wa_n = 2'd0;
    dat_n = OFF;
    if (start) begin
      st_n = WRITE;
      v_n = pick_b ? val_b : val_a;
      d_n = pick_b ? dots_b : dots_a;
      ga_n = !pick_b;
      gb_n = pick_b;
      ls_n = pick_b;
      busy_n = 1'b1;
      en_n = 1'b1;
      dat_n = enc(v_n, d_n, 2'd0);
    end else if (st == WRITE) begin
      st_n = waddr == 2'd3 ? IDLE : WRITE;
      busy_n = waddr != 2'd3;
      en_n = busy_n;
      wa_n = busy_n ? waddr + 2'd1 : 2'd0;
      dat_n = busy_n ? enc(v, d, wa_n) : OFF;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      ra_q <= 1'b0;
      rb_q <= 1'b0;
      v <= 16'h0;
      d <= 4'h0;
      last_src <= 1'b1;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      busy <= 1'b0;
      en_w <= 1'b0;
      waddr <= 2'd0;
      data <= OFF;
    end else begin
      st <= st_n;
      ra_q <= req_a;
      rb_q <= req_b;
      v <= v_n;
      d <= d_n;
      last_src <= ls_n;
      gnt_a <= ga_n;
      gnt_b <= gb_n;
      busy <= busy_n;
      en_w <= en_n;
      waddr <= wa_n;
      data <= dat_n;
    end
  end
endmodule
